// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term path: the generator width,
// the checker state encoding and the recurrence step.
package fib_pkg;

    localparam int FIB_W = 32;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_ONE  = 2'd1,
        CHK_RUN  = 2'd2
    } chk_state_e;

    // Next Fibonacci term; the sum wraps modulo 2^FIB_W.
    function automatic logic [FIB_W-1:0] fib_next(input logic [FIB_W-1:0] a,
                                                  input logic [FIB_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fib_term_fifo_if.sv
// Term capture and drain handshake bundle, plus the status outputs.
// master: generator/consumer side. slave: fib_term_fifo.
interface fib_term_fifo_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              seq_err;
    logic [CNT_W-1:0]  term_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  out_valid, out_data, out_last, full, empty, overflow, seq_err, term_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output out_valid, out_data, out_last, full, empty, overflow, seq_err, term_cnt
    );
endinterface

// File: rtl/fib_sync_fifo.sv
// Generic first-word fall-through synchronous FIFO. Pointers carry one
// extra MSB so full and empty are distinguishable with equal low bits.
module fib_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || rd_en);
    // Head reads as zero when nothing is stored, so stale array data never leaks out.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap modulo 2*DEPTH naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fib_term_fifo.sv
// Fibonacci term buffer: captures generator terms into a FWFT FIFO,
// counts accepted terms per sequence and keeps sticky overflow status.
// Build option FIB_TERM_CHECK_EN adds a recurrence checker driving seq_err;
// without it seq_err is tied low. DATA_W must not exceed fib_pkg::FIB_W.
module fib_term_fifo
    import fib_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    fib_term_fifo_if.slave bus
);
    logic        pop;
    logic        accept;
    logic        drop;
    logic        restart;
    logic [DATA_W:0] head;

    assign bus.out_valid = !bus.empty;
    assign pop    = bus.out_valid && bus.out_ready;
    assign accept = bus.in_valid && (!bus.full || pop);
    assign drop   = bus.in_valid && bus.full && !pop;
    assign bus.out_data = head[DATA_W-1:0];
    assign bus.out_last = head[DATA_W];

    fib_sync_fifo #(.DEPTH(DEPTH), .W(DATA_W+1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (bus.out_ready),
        .wdata ({bus.in_last, bus.in_data}),
        .rdata (head),
        .full  (bus.full),
        .empty (bus.empty)
    );

    // Per-sequence term counter; a term after an accepted last restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.term_cnt <= '0;
            restart      <= 1'b0;
        end else if (accept) begin
            restart <= bus.in_last;
            if (restart)
                bus.term_cnt <= CNT_W'(1);
            else if (bus.term_cnt != '1)
                bus.term_cnt <= bus.term_cnt + CNT_W'(1);
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    bus.overflow <= 1'b0;
        else if (drop) bus.overflow <= 1'b1;
    end

`ifdef FIB_TERM_CHECK_EN
    chk_state_e        state;
    chk_state_e        state_nxt;
    logic [DATA_W-1:0] prev1;
    logic [DATA_W-1:0] prev2;
    logic [DATA_W-1:0] expect_run;
    logic              bad;
    logic              seq_err_q;

    assign expect_run  = DATA_W'(fib_next(FIB_W'(prev1), FIB_W'(prev2)));
    assign bus.seq_err = seq_err_q;

    // Checker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CHK_IDLE;
        else        state <= state_nxt;
    end

    // Checker next state and per-term violation detect; dropped terms never advance it.
    always_comb begin
        state_nxt = state;
        bad       = 1'b0;
        if (accept) begin
            case (state)
                CHK_IDLE: begin
                    bad       = (bus.in_data != '0);
                    state_nxt = CHK_ONE;
                end
                CHK_ONE: begin
                    bad       = (bus.in_data != DATA_W'(1));
                    state_nxt = CHK_RUN;
                end
                CHK_RUN: begin
                    bad       = (bus.in_data != expect_run);
                    state_nxt = CHK_RUN;
                end
                default: state_nxt = CHK_IDLE;
            endcase
            if (bus.in_last) state_nxt = CHK_IDLE;
        end
    end

    // History of the two previous terms, wiped at the end of a sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev1 <= '0;
            prev2 <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                prev1 <= '0;
                prev2 <= '0;
            end else begin
                prev2 <= prev1;
                prev1 <= bus.in_data;
            end
        end
    end

    // Sticky recurrence violation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   seq_err_q <= 1'b0;
        else if (bad) seq_err_q <= 1'b1;
    end
`else
    assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_term_fifo.sv
// Self-checking bench for fib_term_fifo: a behavioural occupancy/counter
// model plus a scoreboard queue of expected FIFO outputs.
module tb_fib_term_fifo;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fib_term_fifo_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    fib_term_fifo_if #(.DATA_W(8),  .CNT_W(CW)) bus8 ();

    fib_term_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    fib_term_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(CW)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    int checks   = 0;
    int failures = 0;

    exp_t          q[$];
    int            m_cnt;
    logic [CW-1:0] m_tc;
    bit            m_restart, m_ovf, m_err;
    int            m_st;
    logic [DW-1:0] m_p1, m_p2;

    task automatic model_clear();
        q.delete();
        m_cnt = 0; m_tc = '0; m_restart = 0; m_ovf = 0; m_err = 0;
        m_st = 0; m_p1 = '0; m_p2 = '0;
    endtask

    // One clock of stimulus; model predicts acceptance and scoreboards accepted terms.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
        bit pop, acc;
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.out_ready = r;
        pop = (m_cnt > 0) && r;
        acc = v && ((m_cnt < DEPTH) || pop);
        if (acc) q.push_back('{d, l});
        @(posedge clk); #1;
        m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
        if (v && !acc) m_ovf = 1;
        if (acc) begin
            if (m_restart)        m_tc = 1;
            else if (m_tc != '1)  m_tc = m_tc + 1'b1;
            m_restart = l;
`ifdef FIB_TERM_CHECK_EN
            case (m_st)
                0:       if (d != 0) m_err = 1;
                1:       if (d != 1) m_err = 1;
                default: if (d != DW'(m_p1 + m_p2)) m_err = 1;
            endcase
            m_st = l ? 0 : ((m_st == 0) ? 1 : 2);
            m_p2 = l ? '0 : m_p1;
            m_p1 = l ? '0 : d;
`endif
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_cnt > 0; i++) drive(0, '0, 0, 1);
        checks++;
        if (bus.empty !== 1'b1 || m_cnt != 0) begin
            failures++;
            $display("FAIL drain_empty got empty=%0b model_cnt=%0d exp empty=1 cnt=0", bus.empty, m_cnt);
        end
    endtask

    // Scoreboard: every pop the DUT performs must match the oldest accepted term.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got data=%0d, scoreboard empty", bus.out_data);
            end else begin
                e = q.pop_front();
                if (bus.out_data !== e.d || bus.out_last !== e.l) begin
                    failures++;
                    $display("FAIL pop_data got %0d/%0b exp %0d/%0b", bus.out_data, bus.out_last, e.d, e.l);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
        bus8.in_valid = 0; bus8.in_data = '0; bus8.in_last = 0; bus8.out_ready = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got empty=%0b full=%0b out_valid=%0b exp 1/0/0", bus.empty, bus.full, bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0 || bus.out_last !== 1'b0 || bus.term_cnt !== '0) begin
            failures++;
            $display("FAIL reset_data got data=%0d last=%0b cnt=%0d exp 0/0/0", bus.out_data, bus.out_last, bus.term_cnt);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.seq_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_sticky got ovf=%0b err=%0b exp 0/0", bus.overflow, bus.seq_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [7] = '{0, 1, 1, 2, 3, 5, 8};
        for (int i = 0; i < 7; i++) begin
            drive(1, vals[i], i == 6, 1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin
                failures++;
                $display("FAIL stream_latency[%0d] got v=%0b d=%0d exp 1/%0d", i, bus.out_valid, bus.out_data, vals[i]);
            end
        end
        checks++;
        if (bus.out_last !== 1'b1 || bus.term_cnt !== CW'(7) || bus.term_cnt !== m_tc) begin
            failures++;
            $display("FAIL stream_end got last=%0b cnt=%0d exp 1/7", bus.out_last, bus.term_cnt);
        end
        checks++;
        if (bus.seq_err !== m_err || bus.seq_err !== 1'b0) begin
            failures++;
            $display("FAIL stream_seq_err got %0b exp 0", bus.seq_err);
        end
        drain();
    endtask

    task automatic test_full_simul();
        logic [DW-1:0] vals [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
        for (int i = 0; i < 8; i++) drive(1, vals[i], 0, 0);
        checks++;
        if (bus.full !== 1'b1) begin
            failures++;
            $display("FAIL full_after_fill got %0b exp 1", bus.full);
        end
        drive(1, 21, 1, 1);
        checks++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.out_data !== DW'(1)) begin
            failures++;
            $display("FAIL full_push_pop got full=%0b ovf=%0b head=%0d exp 1/0/1", bus.full, bus.overflow, bus.out_data);
        end
        checks++;
        if (bus.term_cnt !== m_tc) begin
            failures++;
            $display("FAIL full_push_pop_cnt got %0d exp %0d", bus.term_cnt, m_tc);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] vals [9] = '{0, 1, 1, 2, 3, 5, 8, 13, 21};
        for (int i = 0; i < 9; i++) begin
            drive(1, vals[i], i == 7, 0);
            if (i == 7) begin
                checks++;
                if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_full8 got full=%0b ovf=%0b exp 1/0", bus.full, bus.overflow);
                end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.term_cnt !== CW'(8) || bus.term_cnt !== m_tc) begin
            failures++;
            $display("FAIL ovf_drop got ovf=%0b cnt=%0d exp 1/8", bus.overflow, bus.term_cnt);
        end
        drain();
    endtask

    task automatic test_restart();
        logic [DW-1:0] vals [3] = '{0, 1, 1};
        for (int i = 0; i < 3; i++) begin
            drive(1, vals[i], i == 2, 1);
            checks++;
            if (bus.term_cnt !== CW'(i + 1) || bus.seq_err !== 1'b0) begin
                failures++;
                $display("FAIL restart_cnt[%0d] got cnt=%0d err=%0b exp %0d/0", i, bus.term_cnt, bus.seq_err, i + 1);
            end
        end
        drain();
    endtask

    task automatic test_seq_err();
        logic [DW-1:0] vals [5] = '{0, 1, 1, 2, 4};
        bit exp_final;
`ifdef FIB_TERM_CHECK_EN
        exp_final = 1;
`else
        exp_final = 0;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1, vals[i], i == 4, 1);
            if (i == 3) begin
                checks++;
                if (bus.seq_err !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_err_early got %0b exp 0", bus.seq_err);
                end
            end
        end
        checks++;
        if (bus.seq_err !== exp_final || bus.seq_err !== m_err) begin
            failures++;
            $display("FAIL seq_err_detect got %0b exp %0b", bus.seq_err, exp_final);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.term_cnt !== '0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got empty=%0b v=%0b cnt=%0d ovf=%0b exp 1/0/0/0", bus.empty, bus.out_valid, bus.term_cnt, bus.overflow);
        end
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 1);
        checks++;
        if (bus.term_cnt !== CW'(1) || bus.out_data !== '0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_resume got cnt=%0d d=%0d v=%0b exp 1/0/1", bus.term_cnt, bus.out_data, bus.out_valid);
        end
        drain();
    endtask

    task automatic test_wrap8();
        logic [7:0] a, b, t;
        logic [7:0] q8[$];
        logic [7:0] e;
        a = 8'd0; b = 8'd1;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 0)      t = 8'd0;
            else if (i == 1) t = 8'd1;
            else begin
                t = a + b;
                a = b; b = t;
            end
            q8.push_back(t);
            bus8.in_valid = 1; bus8.in_data = t; bus8.in_last = (i == 14);
            @(posedge clk); #1;
            bus8.in_valid = 0;
            e = q8.pop_front();
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.out_data !== e) begin
                failures++;
                $display("FAIL wrap8_data[%0d] got v=%0b d=%0d exp 1/%0d", i, bus8.out_valid, bus8.out_data, e);
            end
        end
        checks++;
        if (bus8.out_data !== 8'd121 || bus8.seq_err !== 1'b0 || bus8.term_cnt !== CW'(15)) begin
            failures++;
            $display("FAIL wrap8_end got d=%0d err=%0b cnt=%0d exp 121/0/15", bus8.out_data, bus8.seq_err, bus8.term_cnt);
        end
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_simul();
        test_overflow();
        test_restart();
        test_seq_err();
        test_reset_mid();
        test_wrap8();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_term_fifo.md
Name: fib_term_fifo

Overview:
- Downstream stage of the Fibonacci generator: captures each generated term on a valid strobe, buffers it in a small synchronous FIFO, and drains it to the consumer over a valid/ready interface.
- Optionally checks every captured term against the recurrence and flags the first violation.
- Sits between the generator output (fib_out/done) and the consumer, such as a UART or display formatter.

Parameters:
- DATA_W, 32, term width; matches the generator output width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the captured-term counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is immediate, release is synchronous to clk.
- in_valid  in  1  term present on in_data this cycle.
- in_data  in  DATA_W  term value.
- in_last  in  1  final term of the sequence; sampled only when in_valid=1.
- out_valid  out  1  FIFO head available.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  FIFO head term.
- out_last  out  1  head entry was tagged last.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky: a term was dropped because the FIFO was full.
- seq_err  out  1  sticky: recurrence violation detected (feature-dependent).
- term_cnt  out  CNT_W  terms accepted since reset or restart.

Behaviour:
- Reset (rst_n=0): pointers=0, out_valid=0, out_data=0, out_last=0, full=0, empty=1, overflow=0, seq_err=0, term_cnt=0, checker history cleared.
- Storage: DEPTH x (DATA_W+1) array plus wr_ptr/rd_ptr, each log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
- Write: when in_valid=1 and (!full or pop this cycle), the term is stored.
  - term_cnt increments, saturating at all-ones.
- Read: pop when out_valid && out_ready.
  - out_data/out_last are combinational from rd_ptr (first-word fall-through).
  - Latency: a term written in cycle N is visible at out_data in cycle N+1.
- Simultaneous push and pop when full: both occur; occupancy is unchanged; no overflow.
- Push when full with no pop: term dropped, overflow<=1, term_cnt unchanged.
- Pop when empty: ignored; pointers unchanged.
- Pointer wrap: pointers wrap modulo 2*DEPTH.
  - full  = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal).
  - empty = (wr_ptr == rd_ptr).
- Restart: after an accepted term with in_last=1, the next accepted term starts a new sequence.
  - term_cnt restarts at 1.
  - Checker history is cleared.
  - overflow and seq_err stay sticky until rst_n.
- Checker state machine, advanced on each accepted term:
  - IDLE: expects term 0; any other value sets seq_err. Move to ONE.
  - ONE: expects term 1. Move to RUN.
  - RUN: expects in_data == prev1 + prev2, truncated to DATA_W bits (modulo 2^W).
  - prev2<=prev1, prev1<=in_data on every accepted term.
  - in_last returns the checker to IDLE after the check.
  - Dropped terms do not advance the checker.
- Reset mid-operation: all state clears at once; FIFO contents are discarded, and array contents need not be cleared.

Optional Feature:
- Macro: FIB_TERM_CHECK_EN.
- Defined: checker state machine and prev1/prev2 registers present; seq_err behaves as above.
- Undefined: no checker logic; seq_err tied to 0; FIFO and counters unchanged.

Decomposition:
- Package fib_pkg:
  - localparam FIB_W=32.
  - Checker state enum {CHK_IDLE, CHK_ONE, CHK_RUN}.
  - Function fib_next(a,b) returning (a+b) truncated to FIB_W bits.
- One sub-module: fib_sync_fifo (generic DEPTH/width FIFO with full/empty).
  - The top holds the counter, sticky flags and checker.

Test Plan:
- Stream 0,1,1,2,3,5,8 (last on 8) with out_ready=1 -> out_data repeats the values one cycle later, out_last on 8, term_cnt=7, seq_err=0.
- out_ready=0, push 9 terms with DEPTH=8 -> full=1 after the 8th push; the 9th is dropped, overflow=1, term_cnt=8; drain yields the first 8 in order.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> full stays 1, overflow stays 0, head advances.
- Stream 0,1,1,2,4 -> seq_err=1 in the cycle after 4 is accepted. Macro undefined -> seq_err stays 0.
- Sequence ending in_last, then 0,1,1 -> term_cnt reads 1,2,3 and no seq_err. Pull rst_n low mid-stream -> empty=1, out_valid=0 immediately, without waiting for a clock edge.
- DATA_W=8 wraparound: ...,89,144,233 then 121 ((144+233) mod 256) -> no seq_err.
